ternary_dot_engine: RTL and testbench

Streaming ternary-weight dot-product engine: the parametrised successor to the fixed single-shot ternary dot unit. Each beat accepts N ternary weights and N signed activations, reduces them to one partial sum and accumulates over a programmed number of beats. The signed result has selectable saturation and optional ReLU, and is delivered over a valid/ready output. It sits between the weight/activation feeders and the neuron output stage of the fractal network datapath.

---
 rtl/ternary_dot_engine.sv | 85 ++++++++
 tb/tb_ternary_dot_engine.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ternary_dot_engine.sv
// ternary_dot_engine: streaming ternary-weight dot product with two-stage reduce/accumulate.
module ternary_dot_engine #(
  parameter int N = 8,
  parameter int AW = 8,
  parameter int ACC_W = 16,
  parameter int LEN_W = 8,
  parameter int SAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  input  logic               relu,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*N-1:0]     w,
  input  logic [N*AW-1:0]    x,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   result,
  output logic               sat,
  output logic               busy
);
  localparam int PW = AW + $clog2(N) + 1;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state_q;
  logic [LEN_W-1:0] rem_q;
  logic relu_q, sat_q, pv_q, take, ovf;
  logic signed [PW-1:0] psum_q, psum_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W:0] sum;
  assign in_ready = state_q == ACCUM && rem_q != '0;
  assign take = in_valid & in_ready;
  assign out_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign sat = sat_q;
  assign result = relu_q && acc_q[ACC_W-1] ? '0 : acc_q;
  always_comb begin
    psum_d = '0;
    for (int i = 0; i < N; i++)
      psum_d = w[2*i+:2] == 2'b01 ? psum_d + PW'($signed(x[AW*i+:AW])) :
               w[2*i+:2] == 2'b11 ? psum_d - PW'($signed(x[AW*i+:AW])) : psum_d;
  end
  // One guard bit above the accumulator exposes signed overflow for both modes.
  assign sum = (ACC_W+1)'(acc_q) + (ACC_W+1)'(psum_q);
  assign ovf = sum[ACC_W] ^ sum[ACC_W-1];
  always_comb begin
    acc_d = sum[ACC_W-1:0];
    if (ovf && SAT != 0)
      acc_d = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q <= '0;
      relu_q <= 1'b0;
      sat_q <= 1'b0;
      pv_q <= 1'b0;
      psum_q <= '0;
      acc_q <= '0;
    end else begin
      pv_q <= take;
      if (take) psum_q <= psum_d;
      case (state_q)
        IDLE: if (start) begin
          rem_q <= len;
          relu_q <= relu;
          acc_q <= '0;
          sat_q <= 1'b0;
          state_q <= len != '0 ? ACCUM : DONE;
        end
        ACCUM: begin
          if (take) rem_q <= rem_q - LEN_W'(1);
          if (pv_q) begin
            acc_q <= acc_d;
            sat_q <= sat_q | ovf;
          end
          if (rem_q == '0) state_q <= DONE;
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ternary_dot_engine.sv
// tb_ternary_dot_engine: directed checks on a saturating and a wrapping engine driven in parallel.
module tb_ternary_dot_engine;
  logic clk = 0, rst = 1, start = 0, relu = 0, in_valid = 0, out_ready = 0;
  logic [7:0] len = 0;
  logic [15:0] w = 0;
  logic [63:0] x = 0;
  logic rdy_s, rdy_w, ov_s, ov_w, sat_s, sat_w, busy_s, busy_w;
  logic [15:0] res_s, res_w;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;

  ternary_dot_engine #(.SAT(1)) u_sat (.clk(clk), .rst(rst), .start(start), .len(len), .relu(relu),
    .in_valid(in_valid), .in_ready(rdy_s), .w(w), .x(x), .out_valid(ov_s), .out_ready(out_ready),
    .result(res_s), .sat(sat_s), .busy(busy_s));
  ternary_dot_engine #(.SAT(0)) u_wrap (.clk(clk), .rst(rst), .start(start), .len(len), .relu(relu),
    .in_valid(in_valid), .in_ready(rdy_w), .w(w), .x(x), .out_valid(ov_w), .out_ready(out_ready),
    .result(res_w), .sat(sat_w), .busy(busy_w));

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rep(input logic [7:0] v);
    return {8{v}};
  endfunction

  function automatic longint psum_m(input logic [15:0] wv, input logic [63:0] xv);
    longint s = 0;
    for (int i = 0; i < 8; i++) begin
      logic [1:0] c = wv[2*i+:2];
      logic signed [7:0] a = xv[8*i+:8];
      if (c == 2'b01) s += a;
      else if (c == 2'b11) s -= a;
    end
    return s;
  endfunction

  task automatic start_job(input logic [7:0] l, input logic r);
    start = 1; len = l; relu = r;
    tick;
    start = 0;
  endtask

  task automatic send_beat(input logic [15:0] wv, input logic [63:0] xv, input int gap);
    if (gap > 0) begin
      in_valid = 0;
      repeat (gap) tick;
    end
    in_valid = 1; w = wv; x = xv;
    for (int i = 0; i < 20 && !rdy_s; i++) tick;
    if (!rdy_s) chk("in_ready_timeout", 0, 1);
    tick;
  endtask

  task automatic wait_done;
    for (int i = 0; i < 20 && !ov_s; i++) tick;
    chk("done_timeout", ov_s, 1);
  endtask

  task automatic finish_job;
    out_ready = 1;
    tick;
    out_ready = 0;
    chk("ov_drop", ov_s, 0);
    chk("busy_drop", busy_s, 0);
  endtask

  longint exp_acc;
  logic [15:0] bw [6];
  logic [63:0] bx [6];

  initial begin
    tick; tick;
    chk("rst_ready", rdy_s, 0);
    chk("rst_ov", ov_s, 0);
    chk("rst_res", res_s, 0);
    chk("rst_sat", sat_s, 0);
    chk("rst_busy", busy_s, 0);
    rst = 0;
    tick;

    // single beat and its latency
    start_job(1, 0);
    chk("rdy_after_start", rdy_s, 1);
    send_beat(16'h5555, rep(8'd10), 0);
    in_valid = 0;
    chk("single_ov_early", ov_s, 0);
    tick;
    chk("single_ov", ov_s, 1);
    chk("single_res", $signed(res_s), 80);
    chk("single_sat", sat_s, 0);
    finish_job;

    // negative sum, then the same with ReLU
    for (int r = 0; r < 2; r++) begin
      start_job(3, r[0]);
      for (int b = 0; b < 3; b++) send_beat(16'hFFFF, rep(8'd5), 0);
      in_valid = 0;
      wait_done;
      chk(r ? "relu_res" : "neg_res", $signed(res_s), r ? 0 : -120);
      chk(r ? "relu_res_w" : "neg_res_w", $signed(res_w), r ? 0 : -120);
      finish_job;
    end

    // saturation vs wrap over 255 back-to-back beats
    start_job(255, 0);
    for (int b = 0; b < 255; b++) send_beat(16'h5555, rep(8'd127), 0);
    in_valid = 0;
    wait_done;
    chk("sat_res", $signed(res_s), 32767);
    chk("sat_flag", sat_s, 1);
    chk("wrap_res", $signed(res_w), -3064);
    chk("wrap_flag", sat_w, 1);
    finish_job;

    // extreme activations and reserved weight code
    start_job(2, 0);
    send_beat(16'hFFFF, rep(8'h80), 0);
    send_beat(16'hAAAA, rep(8'h7F), 0);
    in_valid = 0;
    wait_done;
    chk("ext_res", $signed(res_s), 1024);
    chk("ext_sat", sat_s, 0);
    finish_job;

    // gaps, ignored start, output backpressure, against the bench model
    exp_acc = 0;
    for (int b = 0; b < 6; b++) begin
      bw[b] = 16'($urandom);
      bx[b] = {$urandom, $urandom};
      exp_acc += psum_m(bw[b], bx[b]);
    end
    start_job(6, 0);
    for (int b = 0; b < 6; b++) begin
      send_beat(bw[b], bx[b], int'($urandom_range(0, 2)));
      if (b == 2) begin
        in_valid = 0;
        start_job(0, 1);
      end
    end
    in_valid = 0;
    wait_done;
    chk("bp_res", $signed(res_s), exp_acc);
    chk("bp_res_w", $signed(res_w), exp_acc);
    for (int c = 0; c < 5; c++) begin
      start = c == 1;
      len = 0;
      tick;
      chk("bp_hold_ov", ov_s, 1);
      chk("bp_hold_res", $signed(res_s), exp_acc);
      chk("bp_hold_sat", sat_s, 0);
    end
    start = 0;
    finish_job;

    // len = 0
    start_job(0, 0);
    chk("len0_ov", ov_s, 1);
    chk("len0_res", res_s, 0);
    finish_job;

    // asynchronous abort mid-job, then a fresh job
    start_job(5, 0);
    send_beat(16'h5555, rep(8'd10), 0);
    send_beat(16'h5555, rep(8'd10), 0);
    in_valid = 0;
    #2 rst = 1;
    #1;
    chk("abort_ready", rdy_s, 0);
    chk("abort_ov", ov_s, 0);
    chk("abort_res", res_s, 0);
    chk("abort_sat", sat_s, 0);
    chk("abort_busy", busy_s, 0);
    tick;
    rst = 0;
    tick;
    start_job(1, 0);
    send_beat(16'h5555, 64'h0807060504030201, 0);
    in_valid = 0;
    wait_done;
    chk("fresh_res", $signed(res_s), 36);
    finish_job;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
